// File: rtl/pdes_pkg.sv
// rtl/pdes_pkg.sv - shared widths, message field offsets and decision codes
package pdes_pkg;

  function automatic int nb_core(input int num_core);
    return (num_core > 1) ? $clog2(num_core) : 1;
  endfunction

  function automatic int nb_lp(input int num_lp);
    return (num_lp > 1) ? $clog2(num_lp) : 1;
  endfunction

  // Message layout: time at the bottom, LP id above it, history count in [31:28].
  localparam int TIME_LSB = 0;
  localparam int HIST_LSB = 28;
  localparam int HIST_WID = 4;

  function automatic int lp_lsb(input int time_wid);
    return TIME_LSB + time_wid;
  endfunction

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_RETURN,
    DEC_ISSUE
  } dec_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts at ptr
import pdes_pkg::*;

module rr_arbiter #(
  parameter  int N  = 4,
  localparam int NB = nb_core(N)
) (
  input  logic [N-1:0]  req,
  input  logic [NB-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [NB-1:0] idx,
  output logic          vld
);

  logic [NB-1:0] cand;

  // N is a power of two, so the NB-bit add wraps the search naturally.
  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + NB'(i);
      if (!vld && req[cand]) begin
        vld         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/event_dispatcher.sv
// rtl/event_dispatcher.sv - issues queued events to idle cores, returns finished ones
import pdes_pkg::*;

module event_dispatcher #(
  parameter  int NUM_CORE = 4,
  parameter  int NUM_LP   = 8,
  parameter  int TIME_WID = 16,
  parameter  int MSG_WID  = 32,
  localparam int NB_CORE  = nb_core(NUM_CORE)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [MSG_WID-1:0]          q_msg,
  input  logic                        q_vld,
  output logic                        q_rdy,
  output logic [MSG_WID-1:0]          enq_msg,
  output logic                        enq_vld,
  input  logic                        enq_rdy,
  input  logic                        halt,
  output logic [MSG_WID-1:0]          core_msg_out,
  output logic [NUM_CORE-1:0]         core_start,
  input  logic [NUM_CORE*MSG_WID-1:0] core_msg_in,
  input  logic [NUM_CORE-1:0]         core_done,
  output logic [NUM_CORE-1:0]         core_ack,
  output logic [MSG_WID-1:0]          mon_msg,
  output logic                        mon_sent_vld,
  output logic                        mon_rcv_vld,
  output logic [NB_CORE-1:0]          mon_core_id,
  output logic [NUM_CORE-1:0]         core_active,
  output logic [NB_CORE:0]            num_active,
  output logic                        idle
);

  if (NUM_CORE < 2 || (NUM_CORE & (NUM_CORE - 1)) != 0 ||
      lp_lsb(TIME_WID) + nb_lp(NUM_LP) > HIST_LSB || MSG_WID < HIST_LSB + HIST_WID) begin : g_bad_cfg
    $error("event_dispatcher: unsupported parameter set");
  end

  logic [NUM_CORE-1:0] core_active_q, core_active_d;
  logic [NB_CORE-1:0]  rr_ptr_q, rr_ptr_d;
  logic [MSG_WID-1:0]  enq_msg_q, enq_msg_d;
  logic                enq_vld_q, enq_vld_d;
  logic [MSG_WID-1:0]  core_msg_out_q, core_msg_out_d;
  logic [NUM_CORE-1:0] core_start_q, core_start_d;
  logic [MSG_WID-1:0]  mon_msg_q, mon_msg_d;
  logic                mon_sent_q, mon_sent_d;
  logic                mon_rcv_q, mon_rcv_d;
  logic [NB_CORE-1:0]  mon_core_id_q, mon_core_id_d;
  logic [NB_CORE:0]    num_active_q, num_active_d;
  logic                idle_q, idle_d;

  logic [NUM_CORE-1:0] ret_req, ret_grant;
  logic [NB_CORE-1:0]  ret_idx, iss_idx;
  logic                ret_vld;
  logic [MSG_WID-1:0]  ret_msg;
  dec_e                dec;

  assign ret_req = core_done & core_active_q;
  assign ret_msg = core_msg_in[int'(ret_idx)*MSG_WID +: MSG_WID];

  rr_arbiter #(.N(NUM_CORE)) u_rr_arbiter (
    .req   (ret_req),
    .ptr   (rr_ptr_q),
    .grant (ret_grant),
    .idx   (ret_idx),
    .vld   (ret_vld)
  );

  always_comb begin
    iss_idx = '0;
    for (int i = NUM_CORE - 1; i >= 0; i--) begin
      if (!core_active_q[i]) iss_idx = NB_CORE'(i);
    end
  end

  // A pending return, even one stalled by enq_rdy, keeps new issues out.
  always_comb begin
    dec = DEC_NONE;
    if (ret_vld) begin
      if (enq_rdy) dec = DEC_RETURN;
    end else if (q_vld && !halt && !(&core_active_q)) begin
      dec = DEC_ISSUE;
    end
  end

  assign q_rdy    = (dec == DEC_ISSUE);
  assign core_ack = (dec == DEC_RETURN) ? ret_grant : '0;

  always_comb begin
    core_active_d  = core_active_q;
    rr_ptr_d       = rr_ptr_q;
    enq_msg_d      = enq_msg_q;
    enq_vld_d      = 1'b0;
    core_msg_out_d = core_msg_out_q;
    core_start_d   = '0;
    mon_msg_d      = mon_msg_q;
    mon_sent_d     = 1'b0;
    mon_rcv_d      = 1'b0;
    mon_core_id_d  = mon_core_id_q;
    num_active_d   = '0;
    case (dec)
      DEC_RETURN: begin
        mon_rcv_d              = 1'b1;
        mon_core_id_d          = ret_idx;
        mon_msg_d              = ret_msg;
        enq_msg_d              = ret_msg;
        enq_vld_d              = 1'b1;
        core_active_d[ret_idx] = 1'b0;
        rr_ptr_d               = ret_idx + NB_CORE'(1);
      end
      DEC_ISSUE: begin
        mon_sent_d             = 1'b1;
        mon_core_id_d          = iss_idx;
        mon_msg_d              = q_msg;
        core_msg_out_d         = q_msg;
        core_start_d[iss_idx]  = 1'b1;
        core_active_d[iss_idx] = 1'b1;
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_CORE; i++) begin
      num_active_d = num_active_d + (NB_CORE+1)'(core_active_d[i]);
    end
    idle_d = (core_active_d == '0) && !q_vld && (dec == DEC_NONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_active_q  <= '0;
      rr_ptr_q       <= '0;
      enq_msg_q      <= '0;
      enq_vld_q      <= 1'b0;
      core_msg_out_q <= '0;
      core_start_q   <= '0;
      mon_msg_q      <= '0;
      mon_sent_q     <= 1'b0;
      mon_rcv_q      <= 1'b0;
      mon_core_id_q  <= '0;
      num_active_q   <= '0;
      idle_q         <= 1'b0;
    end else begin
      core_active_q  <= core_active_d;
      rr_ptr_q       <= rr_ptr_d;
      enq_msg_q      <= enq_msg_d;
      enq_vld_q      <= enq_vld_d;
      core_msg_out_q <= core_msg_out_d;
      core_start_q   <= core_start_d;
      mon_msg_q      <= mon_msg_d;
      mon_sent_q     <= mon_sent_d;
      mon_rcv_q      <= mon_rcv_d;
      mon_core_id_q  <= mon_core_id_d;
      num_active_q   <= num_active_d;
      idle_q         <= idle_d;
    end
  end

  assign core_active  = core_active_q;
  assign enq_msg      = enq_msg_q;
  assign enq_vld      = enq_vld_q;
  assign core_msg_out = core_msg_out_q;
  assign core_start   = core_start_q;
  assign mon_msg      = mon_msg_q;
  assign mon_sent_vld = mon_sent_q;
  assign mon_rcv_vld  = mon_rcv_q;
  assign mon_core_id  = mon_core_id_q;
  assign num_active   = num_active_q;
  assign idle         = idle_q;

endmodule

// File: tb/tb_event_dispatcher.sv
// tb/tb_event_dispatcher.sv - scoreboard bench for event_dispatcher
module tb_event_dispatcher;

  localparam int NC = 4;
  localparam int MW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [MW-1:0]   q_msg;
  logic            q_vld;
  logic            q_rdy;
  logic [MW-1:0]   enq_msg;
  logic            enq_vld;
  logic            enq_rdy;
  logic            halt;
  logic [MW-1:0]   core_msg_out;
  logic [NC-1:0]   core_start;
  logic [NC*MW-1:0] core_msg_in;
  logic [NC-1:0]   core_done;
  logic [NC-1:0]   core_ack;
  logic [MW-1:0]   mon_msg;
  logic            mon_sent_vld;
  logic            mon_rcv_vld;
  logic [1:0]      mon_core_id;
  logic [NC-1:0]   core_active;
  logic [2:0]      num_active;
  logic            idle;

  event_dispatcher #(.NUM_CORE(NC), .NUM_LP(8), .TIME_WID(16), .MSG_WID(MW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .q_msg        (q_msg),
    .q_vld        (q_vld),
    .q_rdy        (q_rdy),
    .enq_msg      (enq_msg),
    .enq_vld      (enq_vld),
    .enq_rdy      (enq_rdy),
    .halt         (halt),
    .core_msg_out (core_msg_out),
    .core_start   (core_start),
    .core_msg_in  (core_msg_in),
    .core_done    (core_done),
    .core_ack     (core_ack),
    .mon_msg      (mon_msg),
    .mon_sent_vld (mon_sent_vld),
    .mon_rcv_vld  (mon_rcv_vld),
    .mon_core_id  (mon_core_id),
    .core_active  (core_active),
    .num_active   (num_active),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sent;
    logic [1:0]    id;
    logic [MW-1:0] msg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_ev(input logic sent, input int id, input logic [MW-1:0] msg);
    exp_t e;
    e.sent = sent;
    e.id   = id[1:0];
    e.msg  = msg;
    sb.push_back(e);
  endtask

  task automatic set_core_msg(input int i, input logic [MW-1:0] m);
    core_msg_in[i*MW +: MW] = m;
  endtask

  task automatic check_zero(input string p);
    check({p, "core_active"},  core_active,  0);
    check({p, "num_active"},   num_active,   0);
    check({p, "core_start"},   core_start,   0);
    check({p, "enq_vld"},      enq_vld,      0);
    check({p, "enq_msg"},      enq_msg,      0);
    check({p, "mon_sent_vld"}, mon_sent_vld, 0);
    check({p, "mon_rcv_vld"},  mon_rcv_vld,  0);
    check({p, "mon_core_id"},  mon_core_id,  0);
    check({p, "mon_msg"},      mon_msg,      0);
    check({p, "core_msg_out"}, core_msg_out, 0);
    check({p, "core_ack"},     core_ack,     0);
    check({p, "q_rdy"},        q_rdy,        0);
    check({p, "idle"},         idle,         0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    q_vld     = 1'b0;
    core_done = '0;
    halt      = 1'b0;
    enq_rdy   = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset_n && (mon_sent_vld || mon_rcv_vld)) begin
      exp_t e;
      check("strobe_mutex", mon_sent_vld & mon_rcv_vld, 0);
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("mon_kind", {mon_sent_vld, mon_rcv_vld}, e.sent ? 2'b10 : 2'b01);
        check("mon_core_id", mon_core_id, e.id);
        check("mon_msg", mon_msg, e.msg);
        if (e.sent) begin
          check("core_start", core_start, 64'd1 << e.id);
          check("core_msg_out", core_msg_out, e.msg);
        end else begin
          check("enq_vld", enq_vld, 1);
          check("enq_msg", enq_msg, e.msg);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    reset_n     = 1'b0;
    q_msg       = '0;
    q_vld       = 1'b0;
    enq_rdy     = 1'b1;
    halt        = 1'b0;
    core_msg_in = '0;
    core_done   = '0;

    @(negedge clk);
    check_zero("rst_");
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", idle, 1);

    // single event
    q_msg = 32'h0003_0010;
    q_vld = 1'b1;
    #1 check("single_q_rdy", q_rdy, 1);
    expect_ev(1'b1, 0, 32'h0003_0010);
    @(negedge clk);
    q_vld = 1'b0;
    check("single_active", core_active, 4'b0001);
    check("single_num_active", num_active, 1);
    @(negedge clk);
    check("single_start_width", core_start, 0);
    check("single_sent_width", mon_sent_vld, 0);

    // fill all cores, fifth event stays queued
    do_reset();
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      q_msg = 32'h00A0_0000 | idx;
      q_vld = 1'b1;
      #1 check("fill_q_rdy", q_rdy, idx < 4);
      if (idx < 4) begin
        expect_ev(1'b1, idx, 32'h00A0_0000 | idx);
        idx++;
      end
      @(negedge clk);
    end
    check("fill_active", core_active, 4'b1111);
    check("fill_num_active", num_active, 4);
    check("fill_q_rdy_full", q_rdy, 0);

    // return beats issue; freed core reissued two cycles after ack
    set_core_msg(2, 32'hC2C2_0002);
    core_done = 4'b0100;
    #1 check("ret_ack", core_ack, 4'b0100);
    check("ret_blocks_issue", q_rdy, 0);
    expect_ev(1'b0, 2, 32'hC2C2_0002);
    @(negedge clk);
    core_done = '0;
    check("ret_active", core_active, 4'b1011);
    check("ret_num_active", num_active, 3);
    #1 check("reissue_q_rdy", q_rdy, 1);
    expect_ev(1'b1, 2, 32'h00A0_0004);
    @(negedge clk);
    q_vld = 1'b0;
    check("reissue_start", core_start, 4'b0100);
    check("reissue_active", core_active, 4'b1111);
    check("enq_width", enq_vld, 0);

    // bring rr_ptr to 1 via a core-0 return, refill core 0
    set_core_msg(0, 32'hC0C0_0000);
    core_done = 4'b0001;
    #1 check("rr_prep_ack", core_ack, 4'b0001);
    expect_ev(1'b0, 0, 32'hC0C0_0000);
    @(negedge clk);
    core_done = '0;
    q_msg = 32'h00B0_0000;
    q_vld = 1'b1;
    #1 check("rr_prep_q_rdy", q_rdy, 1);
    expect_ev(1'b1, 0, 32'h00B0_0000);
    @(negedge clk);
    q_msg = 32'h00B0_0001;
    set_core_msg(0, 32'hD0D0_0000);
    set_core_msg(1, 32'hD1D1_0001);
    set_core_msg(3, 32'hD3D3_0003);
    core_done = 4'b1011;
    #1 check("rr_ack1", core_ack, 4'b0010);
    check("rr_no_issue1", q_rdy, 0);
    expect_ev(1'b0, 1, 32'hD1D1_0001);
    @(negedge clk);
    core_done = 4'b1001;
    #1 check("rr_ack3", core_ack, 4'b1000);
    check("rr_no_issue3", q_rdy, 0);
    expect_ev(1'b0, 3, 32'hD3D3_0003);
    @(negedge clk);
    core_done = 4'b0001;
    #1 check("rr_ack0", core_ack, 4'b0001);
    check("rr_no_issue0", q_rdy, 0);
    expect_ev(1'b0, 0, 32'hD0D0_0000);
    @(negedge clk);
    core_done = '0;
    q_vld = 1'b0;
    check("rr_active", core_active, 4'b0100);
    check("rr_num_active", num_active, 1);

    // backpressure then halt
    for (int k = 0; k < 2; k++) begin
      q_msg = 32'h00E0_0000 | k;
      q_vld = 1'b1;
      #1 check("bp_fill_q_rdy", q_rdy, 1);
      expect_ev(1'b1, k, 32'h00E0_0000 | k);
      @(negedge clk);
    end
    q_msg = 32'h00E0_0002;
    enq_rdy = 1'b0;
    set_core_msg(1, 32'hE1E1_0001);
    core_done = 4'b0010;
    repeat (3) begin
      #1 check("bp_no_ack", core_ack, 0);
      check("bp_no_issue", q_rdy, 0);
      @(negedge clk);
    end
    enq_rdy = 1'b1;
    #1 check("bp_release_ack", core_ack, 4'b0010);
    expect_ev(1'b0, 1, 32'hE1E1_0001);
    @(negedge clk);
    core_done = '0;
    halt = 1'b1;
    #1 check("halt_q_rdy", q_rdy, 0);
    @(negedge clk);
    check("halt_active", core_active, 4'b0101);
    #1 check("halt_q_rdy2", q_rdy, 0);
    halt = 1'b0;
    #1 check("unhalt_q_rdy", q_rdy, 1);
    expect_ev(1'b1, 1, 32'h00E0_0002);
    @(negedge clk);
    q_vld = 1'b0;
    check("unhalt_active", core_active, 4'b0111);

    // async reset while a sent strobe is high
    q_msg = 32'h00F0_0003;
    q_vld = 1'b1;
    #1 check("arst_q_rdy", q_rdy, 1);
    expect_ev(1'b1, 3, 32'h00F0_0003);
    @(negedge clk);
    q_vld = 1'b0;
    check("arst_pre_sent", mon_sent_vld, 1);
    #2 reset_n = 1'b0;
    #1 check_zero("arst_");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_idle", idle, 1);
    check("arst_active", core_active, 0);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/event_dispatcher.md
# event_dispatcher

Drives the core-side protocol that core_monitor observes. It pops events from the event queue, issues each one to an idle core, and collects finished events from cores by round-robin. It pushes returned events back to the queue and generates the sent/receive strobes, core id and core_active vector consumed by core_monitor. It sits between the event queue and the core array, alongside core_monitor.

## Interface
Parameters:
- NUM_CORE, 4: number of cores; power of two, at least 2.
- NUM_LP, 8: number of LPs; sets the width of the LP field.
- TIME_WID, 16: timestamp width; timestamp occupies msg[TIME_WID-1:0].
- MSG_WID, 32: event message width.

Ports (NB_CORE = $clog2(NUM_CORE)):
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- q_msg  in  MSG_WID  head of the event queue.
- q_vld  in  1  queue non-empty.
- q_rdy  out  1  dequeue strobe, combinational; the queue pops at this clock edge.
- enq_msg  out  MSG_WID  returned event to write into the queue.
- enq_vld  out  1  one-cycle write strobe, registered.
- enq_rdy  in  1  queue guarantees it accepts a write on the next cycle.
- halt  in  1  stop issuing new events; returns continue.
- core_msg_out  out  MSG_WID  event broadcast to the cores; held until the next issue.
- core_start  out  NUM_CORE  one-hot, one-cycle start pulse.
- core_msg_in  in  NUM_CORE*MSG_WID  result message of core i in slice [i*MSG_WID +: MSG_WID].
- core_done  in  NUM_CORE  core i holds a result; stays high until acked.
- core_ack  out  NUM_CORE  one-hot, combinational; return accepted this cycle.
- mon_msg  out  MSG_WID  message for core_monitor.
- mon_sent_vld  out  1  event issued to a core.
- mon_rcv_vld  out  1  event returned from a core.
- mon_core_id  out  NB_CORE  core involved in the current strobe.
- core_active  out  NUM_CORE  core i currently owns an event.
- num_active  out  NB_CORE+1  population count of core_active.
- idle  out  1  asserted when core_active==0, q_vld==0 and no strobe is pending.

## Operation
Each cycle is one decision cycle D, and the decision is combinational. The registered effects appear at D+1.

Return path (highest priority):
- Eligible when any core_done[i] & core_active[i] is set and enq_rdy is high.
- The round-robin arbiter picks core g, starting the search at rr_ptr. core_ack[g]=1 in cycle D.
- At D+1: mon_rcv_vld=1, mon_core_id=g, mon_msg=enq_msg=slice g, enq_vld=1, core_active[g]=0.
- rr_ptr is set to g+1 (mod NUM_CORE).

Issue path:
- Eligible only when the return path is not granting, q_vld=1, halt=0, and at least one core_active bit is 0.
- The lowest-index idle core c is chosen; q_rdy=1 in cycle D.
- At D+1: mon_sent_vld=1, mon_core_id=c, mon_msg=core_msg_out=q_msg, core_start[c]=1, core_active[c]=1.

Rules:
- mon_sent_vld and mon_rcv_vld are never high together; core_monitor relies on this.
- core_done on an inactive core is ignored: no ack is given and the arbiter skips it.
- A core freed at D+1 is eligible for issue in decision cycle D+1, so its next start lands at D+2.
- A return blocked by enq_rdy=0 also blocks issue. This is deliberate: it drains cores before filling them.

## Timing
- Reset (async assert, sync-released by the top level): all registered outputs are 0, core_active=0, rr_ptr=0. core_msg_out and mon_msg are 0.
- Reset during operation discards any pending strobes. Cores are reset by the same net.
- Combinational outputs: q_rdy and core_ack.
- Registered outputs: everything else, with 1-cycle latency from the decision.
- Throughput: one strobe per cycle. Sustained issue is one per cycle while idle cores remain.
- Strobe width: core_start, enq_vld, mon_sent_vld and mon_rcv_vld are exactly one cycle.
- core_active updates on the same edge as the matching mon strobe.
- num_active is registered and tracks core_active on the same edge.
- halt is sampled in D and takes effect immediately. A strobe already decided still completes.

## Structure
Shared package (pdes_pkg) holds:
- NB_CORE and NB_LP derivation functions.
- Message field offsets: time [0 +: TIME_WID], LP [TIME_WID +: NB_LP], history count [31:28].

Sub-module rr_arbiter (NUM_CORE-wide request vector plus pointer in; one-hot grant and index out) implements the return-path arbitration. It is reusable by later blocks.

## Test plan
- Reset then single event: q_msg=0x0003_0010 with q_vld for 1 cycle. Expect q_rdy in the same cycle. Next cycle: core_start=0001, mon_sent_vld=1, mon_core_id=0, core_active=0001.
- Fill: 5 events queued, NUM_CORE=4. Expect starts on cores 0,1,2,3 in consecutive cycles, then q_rdy=0 and core_active=1111 until a return.
- Simultaneous return and issue: core 2 done, q_vld=1, enq_rdy=1. Expect the return to win: core_ack=0100, then mon_rcv_vld with mon_core_id=2. The issue goes to core 2 two cycles after the ack.
- Round-robin: cores 0,1,3 done together with rr_ptr=1. Expect acks in order 1, 3, 0 on consecutive cycles, and no mon_sent_vld in between.
- Backpressure and halt: enq_rdy=0 with core 1 done. Expect no ack and no issue. When enq_rdy=1, the return completes. With halt=1, no further q_rdy is given.
- Async reset mid-burst: reset_n low while mon_sent_vld=1. Expect all outputs 0 immediately and core_active=0.
